// File: rtl/sseg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver_pkg
// Shared constants for the multiplexed seven-segment scan driver.
//   SEG_OFF  : active-low pattern with every segment dark
//   SEG_LUT  : active-low glyphs for hex digits 0-F, bit 0 = segment a,
//              bit 6 = segment g (lowercase b and d keep them distinct
//              from 8 and 0)
// -----------------------------------------------------------------------------
package sseg_scan_driver_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

endpackage

// File: rtl/sseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver_if
// Bundles the data-load and display-drive signals of the scan driver.
//   value_i   : 4*NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   blank_i   : per-digit blank, 1 = digit dark
//   dp_i      : per-digit decimal point, 1 = lit
//   load_i    : one-cycle strobe capturing value_i/blank_i/dp_i
//   seg_o     : segments a..g, active-low
//   dp_o      : decimal point, active-low
//   an_o      : digit anodes, active-low
//   frame_o   : one-cycle pulse at the start of each scan frame
//   pending_o : captured data waiting for the frame boundary
// master = the side supplying data, slave = the driver itself.
// -----------------------------------------------------------------------------
interface sseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic                    load_i;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;
    logic                    pending_o;

    modport master (
        output value_i, blank_i, dp_i, load_i,
        input  seg_o, dp_o, an_o, frame_o, pending_o
    );

    modport slave (
        input  value_i, blank_i, dp_i, load_i,
        output seg_o, dp_o, an_o, frame_o, pending_o
    );
endinterface

// File: rtl/sseg_scan_driver_hex.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Purely combinational nibble-to-glyph conversion.
//   nibble_i : hex digit 0-F
//   seg_o    : active-low segments a..g (bit 0 = a)
// -----------------------------------------------------------------------------
module hex_to_7seg
    import sseg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_LUT[nibble_i];
endmodule

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus.
// Each digit owns a slot of REFRESH_DIV cycles whose first BLANK_CYC cycles
// keep every anode off to suppress ghosting. New data is double-buffered and
// only reaches the display at the frame boundary, so a frame never mixes
// old and new digits.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sseg_scan_driver_if.slave (load inputs, display outputs)
// -----------------------------------------------------------------------------
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic clk,
    input  logic rst_n,
    sseg_scan_driver_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [DW-1:0] dig;
    logic          boundary;

    // Pending (load side) and display (scan side) register banks.
    logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
    logic [NUM_DIGITS-1:0]   pend_blank, disp_blank;
    logic [NUM_DIGITS-1:0]   pend_dp,    disp_dp;
    logic                    pending;

    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;

    assign boundary = (cnt == CNT_LAST) && (dig == DIG_LAST);

    // Slot counter and digit index.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer. A load on the boundary cycle bypasses the pending bank
    // and supersedes anything already pending (last write wins).
    // NOTE: these are plain registers, not a RAM, so resetting them is cheap
    // and guarantees a reset discards any half-delivered update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            disp_value <= '0;
            disp_blank <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            if (bus.load_i) begin
                disp_value <= bus.value_i;
                disp_blank <= bus.blank_i;
                disp_dp    <= bus.dp_i;
            end else if (pending) begin
                disp_value <= pend_value;
                disp_blank <= pend_blank;
                disp_dp    <= pend_dp;
            end
            pending <= 1'b0;
        end else if (bus.load_i) begin
            pend_value <= bus.value_i;
            pend_blank <= bus.blank_i;
            pend_dp    <= bus.dp_i;
            pending    <= 1'b1;
        end
    end

    assign bus.pending_o = pending;
    assign cur_nibble    = disp_value[4*dig +: 4];
    assign lit           = (cnt >= BLANK_END) && !disp_blank[dig];

    hex_to_7seg u_hex (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    // At most one anode can ever be driven low: start from all-off and
    // clear only the current digit.
    // NOTE: the default assignment first means every path assigns an_next,
    // so no latch is inferred.
    always_comb begin
        an_next = '1;
        if (lit) an_next[dig] = 1'b0;
    end

    // Registered outputs: one cycle behind cnt/dig/display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an_o    <= '1;
            bus.seg_o   <= SEG_OFF;
            bus.dp_o    <= 1'b1;
            bus.frame_o <= 1'b0;
        end else begin
            bus.an_o    <= an_next;
            bus.seg_o   <= lit ? cur_seg : SEG_OFF;
            bus.dp_o    <= lit ? ~disp_dp[dig] : 1'b1;
            bus.frame_o <= boundary;
        end
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
// Self-checking bench for sseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYC=1. Stimulus pushes expected frames (16 output cycles each) into a
// queue; a monitor on the falling edge starts consuming one armed frame each
// time frame_o is seen and compares an_o/seg_o/dp_o cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sseg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    sseg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLANK_CYC   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    obs_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   armed     = 0;
    int   remaining = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Queue one expected frame: per slot one dark cycle, then three lit
    // cycles (or dark ones if that digit is blanked). Glyphs are given by hand.
    task automatic push_frame(input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3,
                              input logic [3:0] blk, input logic [3:0] dpm);
        logic [6:0] g [4];
        obs_t dark;
        obs_t on;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        dark = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(dark);
            on.an    = 4'hF;
            on.an[i] = 1'b0;
            on.seg   = g[i];
            on.dp    = ~dpm[i];
            for (int k = 0; k < 3; k++) exp_q.push_back(blk[i] ? dark : on);
        end
        armed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.frame_o && n < 64);
        check("frame_wait", bus.frame_o, 1);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
        bus.value_i = v;
        bus.blank_i = b;
        bus.dp_i    = d;
        bus.load_i  = 1'b1;
        tick();
        bus.load_i  = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            check("an_onehot", 32'($countones(~bus.an_o) <= 1), 1);
            if (remaining > 0) begin
                e = exp_q.pop_front();
                check("scan_obs", {bus.an_o, bus.seg_o, bus.dp_o}, e);
                remaining--;
            end
            if (bus.frame_o && armed > 0 && remaining == 0) begin
                armed--;
                remaining = 16;
            end
        end
    end

    initial begin
        int n;
        bus.value_i = '0;
        bus.blank_i = '0;
        bus.dp_i    = '0;
        bus.load_i  = 1'b0;

        // Power-on reset.
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_an",      bus.an_o, 4'hF);
        check("rst_seg",     bus.seg_o, 7'h7F);
        check("rst_dp",      bus.dp_o, 1);
        check("rst_pending", bus.pending_o, 0);
        check("rst_frame",   bus.frame_o, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Slot 0 starts dark, then digit 0 (value 0) lights.
        tick();
        check("start_dark", bus.an_o, 4'hF);
        tick();
        check("start_an0",  bus.an_o, 4'hE);
        check("start_seg0", bus.seg_o, 7'h40);

        // Basic scan of 1234 and frame period.
        load(16'h1234, 4'b0000, 4'b0000);
        check("scan_pending", bus.pending_o, 1);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 4'b0000);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000, 4'b0000);
        wait_frame(n);
        check("scan_pending_clr", bus.pending_o, 0);
        tick();
        check("frame_width", bus.frame_o, 0);
        wait_frame(n);
        check("frame_period", n, 15);

        // Tear-free update: ABCD loaded mid-frame, current frame stays 1234.
        repeat (3) tick();
        load(16'hABCD, 4'b0000, 4'b0000);
        check("tear_pending", bus.pending_o, 1);
        push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b0000, 4'b0000);
        repeat (10) tick();
        check("tear_pending_hold", bus.pending_o, 1);
        wait_frame(n);
        check("tear_pending_clr", bus.pending_o, 0);

        // Boundary collision: load on state cycle 15.
        push_frame(7'h12, 7'h12, 7'h12, 7'h12, 4'b0000, 4'b0000);
        repeat (15) tick();
        load(16'h5555, 4'b0000, 4'b0000);
        check("coll_frame",   bus.frame_o, 1);
        check("coll_pending", bus.pending_o, 0);

        // Last write wins within one frame.
        repeat (2) tick();
        load(16'h1111, 4'b0000, 4'b0000);
        repeat (2) tick();
        load(16'h2222, 4'b0000, 4'b0000);
        check("lww_pending", bus.pending_o, 1);
        push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b0000, 4'b0000);
        wait_frame(n);

        // Blank digit 1, decimal point on digit 0.
        load(16'h8888, 4'b0010, 4'b0001);
        push_frame(7'h00, 7'h00, 7'h00, 7'h00, 4'b0010, 4'b0001);
        wait_frame(n);
        wait_frame(n);

        // Mid-frame reset with a load pending.
        repeat (4) tick();
        load(16'h9999, 4'b0000, 4'b0000);
        check("mrst_pre_pending", bus.pending_o, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_an",      bus.an_o, 4'hF);
        check("mrst_seg",     bus.seg_o, 7'h7F);
        check("mrst_dp",      bus.dp_o, 1);
        check("mrst_pending", bus.pending_o, 0);
        check("mrst_frame",   bus.frame_o, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("mrst_start_dark", bus.an_o, 4'hF);
        tick();
        check("mrst_start_an0",  bus.an_o, 4'hE);
        check("mrst_start_seg0", bus.seg_o, 7'h40);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 4'b0000);
        wait_frame(n);
        wait_frame(n);

        n = 0;
        while ((exp_q.size() != 0 || remaining != 0) && n < 40) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
